sel_scan_seq: RTL and testbench



---
 rtl/sel_scan_seq_pkg.sv | 15 +
 rtl/sel_next_ch.sv | 40 ++++
 rtl/sel_scan_seq.sv | 186 ++++++++++++++++++
 tb/tb_sel_scan_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sel_scan_seq_pkg.sv
// Shared definitions for the select-code scan sequencer.
// Holds the state encoding, the select-code width and the channel count,
// imported by sel_next_ch and sel_scan_seq.
package sel_scan_seq_pkg;

  localparam int SEL_W = 3;
  localparam int NCH   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

endpackage

// File: rtl/sel_next_ch.sv
// Rotating priority search for the next enabled channel above a given code.
// Ports:
//   mask  in  NCH    channel enable mask (bit n enables channel n)
//   cur   in  SEL_W  current channel code; the search starts at cur+1
//   nxt   out SEL_W  first enabled channel found going upward with wrap
//   wrap  out 1      the found channel is at or below cur (wrapped around)
//   none  out 1      mask is empty; nxt is 0 and wrap is 0
// With cur = NCH-1 the search starts at channel 0, so nxt is the lowest set
// bit of mask.
module sel_next_ch
  import sel_scan_seq_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic             wrap,
  output logic             none
);

  logic [SEL_W-1:0] idx;
  logic             found;

  always_comb begin
    nxt   = '0;
    idx   = '0;
    found = 1'b0;
    none  = (mask == '0);
    // The last step (k = NCH) lands back on cur itself, which covers the
    // single-enabled-channel case.
    for (int k = 1; k <= NCH; k++) begin
      idx = cur + SEL_W'(k);
      if (!found && mask[idx]) begin
        found = 1'b1;
        nxt   = idx;
      end
    end
    wrap = found && (nxt <= cur);
  end

endmodule

// File: rtl/sel_scan_seq.sv
// Scan sequencer that steps a 3-bit select code through the enabled channels
// of an 8-channel mask, holding each for a programmable dwell, optionally
// blanking between channels, and pulsing frame_done on every wrap.
// Ports:
//   clk1        in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   en          in   scan enable; low forces IDLE on the next cycle
//   load        in   strobe capturing mask_in/dwell_in into the shadow regs
//   mask_in     in   [7:0] channel enable mask
//   dwell_in    in   [DWELL_W-1:0] dwell length in cycles (0 acts as 1)
//   select      out  [2:0] current channel code
//   sel_valid   out  high while select is driven (SCAN)
//   frame_done  out  one-cycle pulse when select wraps to the first channel
//   busy        out  high in any state other than IDLE
//   state       out  [1:0] current FSM state (debug visibility)
// Shadow values reach the active registers only while IDLE or at the frame
// boundary, so a frame in progress always finishes with the settings it
// started with.
module sel_scan_seq
  import sel_scan_seq_pkg::*;
#(
  parameter int         DWELL_W   = 16,
  parameter int         DWELL_DEF = 50000,
  parameter int         BLANK_CYC = 4,
  parameter logic [7:0] MASK_DEF  = 8'hFF
) (
  input  logic               clk1,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [7:0]         mask_in,
  input  logic [DWELL_W-1:0] dwell_in,
  output logic [2:0]         select,
  output logic               sel_valid,
  output logic               frame_done,
  output logic               busy,
  output logic [1:0]         state
);

  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  state_t             st;
  logic [DWELL_W-1:0] cnt;
  logic [BW-1:0]      bcnt;
  logic [NCH-1:0]     act_mask, sh_mask, eff_mask;
  logic [DWELL_W-1:0] act_dwell, sh_dwell, eff_dwell, dwell_last;

  logic [SEL_W-1:0]   ring_nxt, low_nxt, adv_sel;
  logic               ring_wrap, ring_none, low_wrap, low_none, low_ok;
  logic               do_adv, adv_idle, adv_frame;

  // Next channel within the running frame.
  sel_next_ch u_ring (
    .mask (act_mask),
    .cur  (select),
    .nxt  (ring_nxt),
    .wrap (ring_wrap),
    .none (ring_none)
  );

  // First channel of a new frame, taken from the settings about to become
  // active (a load in this very cycle wins over the stored shadow).
  sel_next_ch u_low (
    .mask (eff_mask),
    .cur  (3'd7),
    .nxt  (low_nxt),
    .wrap (low_wrap),
    .none (low_none)
  );

  always_comb begin
    eff_mask   = load ? mask_in  : sh_mask;
    eff_dwell  = load ? dwell_in : sh_dwell;
    dwell_last = (act_dwell == '0) ? '0 : act_dwell - 1'b1;
    // A search starting from 7 wraps exactly when some channel is set.
    low_ok     = low_wrap && !low_none;

    do_adv = 1'b0;
    if (st == ST_SCAN && cnt == dwell_last && BLANK_CYC == 0)
      do_adv = 1'b1;
    if (st == ST_BLANK && bcnt == BLANK_LAST)
      do_adv = 1'b1;

    adv_idle  = 1'b0;
    adv_frame = 1'b0;
    adv_sel   = ring_nxt;
    if (ring_none) begin
      adv_idle = 1'b1;
    end else if (ring_wrap) begin
      if (low_ok) begin
        adv_sel   = low_nxt;
        adv_frame = 1'b1;
      end else begin
        adv_idle = 1'b1;
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      st         <= ST_IDLE;
      select     <= '0;
      sel_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      cnt        <= '0;
      bcnt       <= '0;
      act_mask   <= MASK_DEF;
      sh_mask    <= MASK_DEF;
      act_dwell  <= DWELL_W'(DWELL_DEF);
      sh_dwell   <= DWELL_W'(DWELL_DEF);
    end else begin
      frame_done <= 1'b0;
      if (load) begin
        sh_mask  <= mask_in;
        sh_dwell <= dwell_in;
      end
      if (st == ST_IDLE) begin
        act_mask  <= eff_mask;
        act_dwell <= eff_dwell;
      end

      if (!en) begin
        st        <= ST_IDLE;
        select    <= '0;
        sel_valid <= 1'b0;
        busy      <= 1'b0;
        cnt       <= '0;
        bcnt      <= '0;
      end else if (do_adv) begin
        cnt  <= '0;
        bcnt <= '0;
        if (ring_wrap) begin
          act_mask  <= eff_mask;
          act_dwell <= eff_dwell;
        end
        if (adv_idle) begin
          st        <= ST_IDLE;
          select    <= '0;
          sel_valid <= 1'b0;
          busy      <= 1'b0;
        end else begin
          st         <= ST_SCAN;
          select     <= adv_sel;
          sel_valid  <= 1'b1;
          busy       <= 1'b1;
          frame_done <= adv_frame;
        end
      end else begin
        case (st)
          ST_IDLE: begin
            if (low_ok) begin
              st        <= ST_SCAN;
              select    <= low_nxt;
              sel_valid <= 1'b1;
              busy      <= 1'b1;
              cnt       <= '0;
            end
          end
          ST_SCAN: begin
            // Reaching the last dwell cycle here implies a blanking gap.
            if (cnt == dwell_last) begin
              st        <= ST_BLANK;
              sel_valid <= 1'b0;
              cnt       <= '0;
              bcnt      <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_BLANK: bcnt <= bcnt + 1'b1;
          default: begin
            st        <= ST_IDLE;
            select    <= '0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_sel_scan_seq.sv
// Directed bench for sel_scan_seq: one instance without blanking (u0) and
// one with a 4-cycle blanking gap (u4), both with a short default dwell.
module tb_sel_scan_seq;

  logic       clk1;
  logic       rst;

  logic       en0, load0;
  logic [7:0] mask0;
  logic [7:0] dwell0;
  logic [2:0] select0;
  logic       valid0, fd0, busy0;
  logic [1:0] state0;

  logic       en4, load4;
  logic [7:0] mask4;
  logic [7:0] dwell4;
  logic [2:0] select4;
  logic       valid4, fd4, busy4;
  logic [1:0] state4;

  int checks = 0;
  int errors = 0;
  int chs[3] = '{2, 5, 7};

  sel_scan_seq #(.DWELL_W(8), .DWELL_DEF(5), .BLANK_CYC(0), .MASK_DEF(8'hFF)) u0 (
    .clk1(clk1), .rst(rst), .en(en0), .load(load0), .mask_in(mask0),
    .dwell_in(dwell0), .select(select0), .sel_valid(valid0),
    .frame_done(fd0), .busy(busy0), .state(state0)
  );

  sel_scan_seq #(.DWELL_W(8), .DWELL_DEF(5), .BLANK_CYC(4), .MASK_DEF(8'hFF)) u4 (
    .clk1(clk1), .rst(rst), .en(en4), .load(load4), .mask_in(mask4),
    .dwell_in(dwell4), .select(select4), .sel_valid(valid4),
    .frame_done(fd4), .busy(busy4), .state(state4)
  );

  // clock / reset
  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect0(input string tag, input int sel, input int v, input int fd, input int b);
    check({tag, ".sel"},   32'(select0), 32'(sel));
    check({tag, ".valid"}, 32'(valid0),  32'(v));
    check({tag, ".fd"},    32'(fd0),     32'(fd));
    check({tag, ".busy"},  32'(busy0),   32'(b));
  endtask

  task automatic expect4(input string tag, input int sel, input int v, input int fd, input int b);
    check({tag, ".sel"},   32'(select4), 32'(sel));
    check({tag, ".valid"}, 32'(valid4),  32'(v));
    check({tag, ".fd"},    32'(fd4),     32'(fd));
    check({tag, ".busy"},  32'(busy4),   32'(b));
  endtask

  initial begin
    rst = 1'b1;
    en0 = 1'b0; load0 = 1'b0; mask0 = 8'h00; dwell0 = 8'd0;
    en4 = 1'b0; load4 = 1'b0; mask4 = 8'h00; dwell4 = 8'd0;
    repeat (3) tick();

    // reset state
    expect0("rst0", 0, 0, 0, 0);
    check("rst0.state", 32'(state0), 32'd0);
    expect4("rst4", 0, 0, 0, 0);
    check("rst4.state", 32'(state4), 32'd0);

    // mask FF, dwell 3, no blanking
    rst = 1'b0;
    en0 = 1'b1; load0 = 1'b1; mask0 = 8'hFF; dwell0 = 8'd3;
    tick();
    load0 = 1'b0;
    for (int i = 0; i <= 24; i++) begin
      expect0($sformatf("t1.%0d", i), (i / 3) % 8, 1, (i == 24) ? 1 : 0, 1);
      tick();
    end

    // dwell 0 acts as 1
    en0 = 1'b0;
    tick();
    expect0("t6.idle", 0, 0, 0, 0);
    en0 = 1'b1; load0 = 1'b1; mask0 = 8'hFF; dwell0 = 8'd0;
    tick();
    load0 = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      expect0($sformatf("t6.%0d", i), i % 8, 1, (i == 8) ? 1 : 0, 1);
      tick();
    end

    // reset mid-scan, then restart with default mask/dwell (5 cycles)
    rst = 1'b1;
    tick();
    expect0("t6.rst", 0, 0, 0, 0);
    check("t6.rst.state", 32'(state0), 32'd0);
    rst = 1'b0;
    tick();
    expect0("t6.def0", 0, 1, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      expect0($sformatf("t6.def%0d", i), 0, 1, 0, 1);
    end
    tick();
    expect0("t6.def5", 1, 1, 0, 1);
    en0 = 1'b0;

    // sparse mask with blanking
    en4 = 1'b1; load4 = 1'b1; mask4 = 8'b1010_0100; dwell4 = 8'd2;
    tick();
    load4 = 1'b0;
    for (int i = 0; i < 18; i++) begin
      expect4($sformatf("t2.%0d", i), chs[i / 6], ((i % 6) < 2) ? 1 : 0, 0, 1);
      if ((i % 6) == 3) check($sformatf("t2.%0d.state", i), 32'(state4), 32'd2);
      tick();
    end
    expect4("t2.wrap", 2, 1, 1, 1);

    // mid-frame load of mask 01 while on channel 3
    en4 = 1'b0;
    tick();
    expect4("t3.idle", 0, 0, 0, 0);
    en4 = 1'b1; load4 = 1'b1; mask4 = 8'hFF; dwell4 = 8'd2;
    tick();
    load4 = 1'b0;
    for (int i = 0; i <= 60; i++) begin
      if (i < 48)
        expect4($sformatf("t3.%0d", i), i / 6, ((i % 6) < 2) ? 1 : 0, 0, 1);
      else
        expect4($sformatf("t3.%0d", i), 0, (((i - 48) % 6) < 2) ? 1 : 0,
                (((i - 48) % 6) == 0) ? 1 : 0, 1);
      if (i == 18) begin
        load4 = 1'b1; mask4 = 8'h01;
      end
      tick();
      load4 = 1'b0;
    end

    // empty mask loaded mid-frame
    en4 = 1'b0;
    tick();
    en4 = 1'b1; load4 = 1'b1; mask4 = 8'hFF; dwell4 = 8'd2;
    tick();
    load4 = 1'b0;
    for (int i = 0; i < 48; i++) begin
      expect4($sformatf("t4.%0d", i), i / 6, ((i % 6) < 2) ? 1 : 0, 0, 1);
      if (i == 10) begin
        load4 = 1'b1; mask4 = 8'h00;
      end
      tick();
      load4 = 1'b0;
    end
    expect4("t4.idle0", 0, 0, 0, 0);
    check("t4.idle0.state", 32'(state4), 32'd0);
    tick();
    expect4("t4.idle1", 0, 0, 0, 0);
    tick();
    expect4("t4.idle2", 0, 0, 0, 0);
    load4 = 1'b1; mask4 = 8'h10;
    tick();
    load4 = 1'b0;
    expect4("t4.start", 4, 1, 0, 1);

    // en dropped during blanking, re-raised 5 cycles later
    tick();
    expect4("t5.scan1", 4, 1, 0, 1);
    tick();
    expect4("t5.blank", 4, 0, 0, 1);
    en4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect4($sformatf("t5.off%0d", i), 0, 0, 0, 0);
    end
    en4 = 1'b1;
    tick();
    expect4("t5.re0", 4, 1, 0, 1);
    tick();
    expect4("t5.re1", 4, 1, 0, 1);
    tick();
    expect4("t5.re2", 4, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
